demux1to4_stream: RTL
=====================

# demux1to4_stream

Stream demultiplexer: the routing counterpart of the 2:1/4:1 selector family. It takes one valid/ready input stream carrying a data word and a 2-bit destination select. It delivers each word to exactly one of four registered output channels, each with its own valid/ready handshake. It sits between a single producer and four independent consumers, and it never drops or duplicates a word.

## Interface
- DW, default 8: data width of the input word and of each output channel.
- CNT_W, default 8: width of each per-channel delivery counter (only with the counter feature).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- in_sel  in  2  destination channel 0..3; sampled with in_data.
- in_data  in  DW  input word.
- out_valid  out  4  bit k means channel k holds a word.
- out_ready  in  4  bit k means consumer k takes the word this cycle.
- out_data  out  4*DW  channel k occupies bits [k*DW +: DW].
- cnt_clr  in  1  synchronous clear of all counters (counter feature only).
- out_cnt  out  4*CNT_W  words delivered per channel (counter feature only).

## Operation
- Each channel has a one-entry slot with two states, EMPTY and FULL.
  - EMPTY → FULL on accept with in_sel == k.
  - FULL → EMPTY on out_valid[k] && out_ready[k] with no same-cycle accept to k.
  - FULL stays FULL on a same-cycle drain and accept to k; the slot loads the new word.
- out_valid[k] is 1 exactly when slot k is FULL. out_data[k] is the slot register.
- in_ready = (slot[in_sel] == EMPTY) || out_ready[in_sel].
  - This is combinational through out_ready of the selected channel only.
  - in_ready does not depend on in_valid.
- Accept condition: in_valid && in_ready. Data and select are captured only on accept.
- Non-selected channels are unaffected by input traffic and drain independently.
- A full channel k stalls only words addressed to k. There is no reordering within a channel.
- Words to different channels may complete out of input order. This is allowed.
- While FULL and not accepted, out_data[k] must be held stable.

## Timing
- Reset (async, rst_n = 0): all slots EMPTY, out_valid = 4'b0000, out_data = 0, out_cnt = 0.
  - in_ready reads 1 during and after reset, since every slot is empty.
- Latency: a word accepted at edge N is visible on out_valid[k]/out_data[k] after edge N.
- Throughput: 1 word/cycle to any channel, including back-to-back to the same channel whose consumer holds out_ready = 1.
- Simultaneous drain and accept on the same channel: the old word completes, the new word loads, and out_valid stays 1 with no bubble.
- Reset mid-operation: stored words are discarded, with no partial delivery. The first accept after release behaves as after a cold reset.
- in_sel or in_data changing while in_valid = 1 and in_ready = 0 is legal. The value present at the accepting edge wins.

## Configuration
- DEMUX_CNT_EN defined: a per-channel CNT_W-bit counter increments on each out_valid[k] && out_ready[k].
  - Counters wrap from 2^CNT_W−1 to 0.
  - cnt_clr = 1 zeroes all counters at the next edge. Clear wins over a same-cycle increment.
- DEMUX_CNT_EN undefined: there are no counter registers. The cnt_clr port is ignored and out_cnt is tied to 0.
  - The port list is unchanged in both builds.

## Structure
- Package demux_pkg holds:
  - N_OUT = 4 and SEL_W = 2.
  - Slot state enum {SLOT_EMPTY, SLOT_FULL}.
- Sub-module demux_out_slot: a one-entry register slice, instantiated four times.
  - Ports: clk, rst_n, load, data_in, drain, valid, data.
- The top level contains:
  - In-ready select.
  - Load decode.
  - Optional counters.

## Test plan
- Reset, then four words 0xA0..0xA3 with in_sel = 0..3 and all out_ready = 1 → each appears on its channel 1 cycle after accept; in_ready stays 1 throughout.
- out_ready[2] = 0: send 0x11 then 0x22 to ch2.
  - 0x11 is held on ch2 and in_ready = 0 for the second word.
  - Raising out_ready[2] delivers 0x11, then 0x22 on the next cycle.
- ch2 blocked and full, then a word 0x33 to ch1 → in_ready = 1 and 0x33 is delivered on ch1 without waiting.
- ch0 FULL with out_ready[0] = 1 and a new word 0x55 to ch0 in the same cycle → out_valid[0] stays 1 and out_data[0] shows 0x55 next cycle.
- rst_n pulsed low while ch3 holds 0x77 → out_valid = 0 immediately; 0x77 is never delivered.
- With DEMUX_CNT_EN: 257 deliveries on ch1 give out_cnt[ch1] = 1. cnt_clr coinciding with a delivery gives 0.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and slot state type for the demux1to4_stream block.
package demux_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : demux_pkg

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-entry register slice holding a single word for one
// output channel. A load always wins over a drain, so a same-cycle drain and
// load keeps the slot full with the new word and no bubble.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] data_in,
  input  logic          drain,
  output logic          valid,
  output logic [DW-1:0] data
);

  slot_state_e   state_q, state_d;
  logic [DW-1:0] data_q, data_d;

  // Next-state and next-data selection for the slot.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = data_in;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
      data_d  = data_q;
    end else begin
      state_d = state_q;
      data_d  = data_q;
    end
  end

  // Slot state and word registers; reset discards any stored word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  assign data  = data_q;

endmodule : demux_out_slot

// File: rtl/demux1to4_stream.sv
// demux1to4_stream: routes one valid/ready input stream to four registered
// output channels selected by in_sel. Optional per-channel delivery counters
// are built only when the DEMUX_CNT_EN macro is defined; otherwise cnt_clr is
// ignored and out_cnt reads zero.
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [DW-1:0]          in_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*DW-1:0]    out_data,
  input  logic                   cnt_clr,
  output logic [N_OUT*CNT_W-1:0] out_cnt
);

  logic             accept_s;
  logic [N_OUT-1:0] load_s;
  logic [N_OUT-1:0] drain_s;

  // Only the addressed channel gates the input: it must be empty or draining now.
  assign in_ready = (!out_valid[in_sel]) || out_ready[in_sel];
  assign accept_s = in_valid && in_ready;
  assign drain_s  = out_valid & out_ready;

  // Load decode: one-hot strobe to the addressed slot on an accepted word.
  always_comb begin
    load_s = {N_OUT{1'b0}};
    if (accept_s) begin
      load_s[in_sel] = 1'b1;
    end else begin
      load_s = {N_OUT{1'b0}};
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_out_slot #(.DW(DW)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_s[k]),
      .data_in (in_data),
      .drain   (drain_s[k]),
      .valid   (out_valid[k]),
      .data    (out_data[k*DW +: DW])
    );
  end

`ifdef DEMUX_CNT_EN
  logic [N_OUT-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Counter next-state: clear beats increment; counters wrap naturally.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (cnt_clr) begin
        cnt_d[k] = {CNT_W{1'b0}};
      end else if (drain_s[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  // Per-channel delivery counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {(N_OUT*CNT_W){1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`else
  logic unused_cnt_clr_s;
  assign unused_cnt_clr_s = cnt_clr;
  assign out_cnt          = {(N_OUT*CNT_W){1'b0}};
`endif

endmodule : demux1to4_stream
